// File: rtl/spi_frame_ctrl.sv
// Frame sequencer ahead of the SPI byte controller: TX/RX byte FIFOs, chip-select
// ownership and the W_STB/W_ACK byte handshake with an acknowledge timeout.
module spi_frame_ctrl #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic          IN_SCLK,
  input  logic          RST,
  input  logic          TX_WR,
  input  logic [7:0]    TX_DATA,
  output logic          TX_FULL,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic          RX_OVF,
  input  logic          RX_RD,
  output logic [7:0]    RX_DATA,
  output logic          RX_EMPTY,
  output logic [AW:0]   RX_CNT,
  output logic          CS,
  output logic          W_STB,
  output logic [7:0]    W_DATA,
  input  logic          W_ACK,
  input  logic          R_STB,
  input  logic [7:0]    R_DATA
);

  localparam int unsigned CW = 4;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(ACK_TIMEOUT);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   to_cnt;
  logic            abort;

  logic [7:0]      tx_mem [DEPTH];
  logic [AW-1:0]   tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]     tx_cnt;
  logic            tx_empty, tx_push, tx_pop, tx_flush;

  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]     rx_cnt;
  logic            rx_full, rx_push, rx_drop, rx_pop;

  logic            start_acc;

  // Handshake decode shared by the FSM and both FIFOs.
  always_comb begin
    tx_empty  = (tx_cnt == '0);
    TX_FULL   = (tx_cnt == FULL_CNT);
    start_acc = (state == S_IDLE) && !BUSY && START && !tx_empty;
    tx_pop    = ((state == S_SETUP) && (cnt == SETUP_LAST)) ||
                ((state == S_WAIT) && W_ACK && !tx_empty);
    tx_flush  = (state == S_WAIT) && !W_ACK && (to_cnt == TO_MAX);
    tx_push   = TX_WR && !TX_FULL && !tx_flush;
    RX_EMPTY  = (rx_cnt == '0);
    rx_full   = (rx_cnt == FULL_CNT);
    rx_push   = R_STB && !CS && !rx_full;
    rx_drop   = R_STB && !CS && rx_full;
    rx_pop    = RX_RD && !RX_EMPTY;
    RX_CNT    = rx_cnt;
    RX_DATA   = RX_EMPTY ? 8'h00 : rx_mem[rx_rd_ptr];
  end

  always_ff @(posedge IN_SCLK) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= TX_DATA;
    if (rx_push) rx_mem[rx_wr_ptr] <= R_DATA;
  end

  // TX pointers; an abort discards everything still queued.
  always_ff @(posedge IN_SCLK or negedge RST) begin
    if (!RST) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else if (tx_flush) begin
      tx_rd_ptr <= tx_wr_ptr;
      tx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
  end

  always_ff @(posedge IN_SCLK or negedge RST) begin
    if (!RST) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      RX_OVF    <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      if (start_acc)    RX_OVF <= 1'b0;
      else if (rx_drop) RX_OVF <= 1'b1;
    end
  end

  // Frame FSM; BUSY stays up through the DONE cycle and drops the cycle after.
  always_ff @(posedge IN_SCLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      to_cnt <= '0;
      abort  <= 1'b0;
      CS     <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      W_STB  <= 1'b0;
      W_DATA <= 8'h00;
    end else begin
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      W_STB <= 1'b0;
      case (state)
        S_IDLE: begin
          if (BUSY) begin
            BUSY <= 1'b0;
          end else if (start_acc) begin
            state <= S_SETUP;
            CS    <= 1'b0;
            BUSY  <= 1'b1;
            cnt   <= '0;
            abort <= 1'b0;
          end else if (START) begin
            DONE <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state  <= S_SEND;
            W_STB  <= 1'b1;
            W_DATA <= tx_mem[tx_rd_ptr];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SEND: begin
          state  <= S_WAIT;
          to_cnt <= TW'(1);
        end
        S_WAIT: begin
          if (W_ACK) begin
            if (!tx_empty) begin
              state  <= S_SEND;
              W_STB  <= 1'b1;
              W_DATA <= tx_mem[tx_rd_ptr];
            end else begin
              state <= S_HOLD;
              cnt   <= '0;
            end
          end else if (to_cnt == TO_MAX) begin
            abort <= 1'b1;
            state <= S_HOLD;
            cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_IDLE;
            CS    <= 1'b1;
            DONE  <= 1'b1;
            ERR   <= abort;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: reset state, frames, timeout, FIFO bounds,
// streaming extension and asynchronous reset mid-frame.
module tb_spi_frame_ctrl;

  localparam int CS_SETUP    = 2;
  localparam int CS_HOLD     = 2;
  localparam int ACK_TIMEOUT = 64;

  logic       IN_SCLK = 1'b0;
  logic       RST = 1'b0;
  logic       TX_WR = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_FULL;
  logic       START = 1'b0;
  logic       BUSY, DONE, ERR, RX_OVF;
  logic       RX_RD = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_EMPTY;
  logic [4:0] RX_CNT;
  logic       CS, W_STB;
  logic [7:0] W_DATA;
  logic       W_ACK = 1'b0;
  logic       R_STB = 1'b0;
  logic [7:0] R_DATA = 8'h00;

  spi_frame_ctrl #(.DEPTH(16), .AW(4), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                   .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .IN_SCLK(IN_SCLK), .RST(RST), .TX_WR(TX_WR), .TX_DATA(TX_DATA), .TX_FULL(TX_FULL),
    .START(START), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RX_OVF(RX_OVF),
    .RX_RD(RX_RD), .RX_DATA(RX_DATA), .RX_EMPTY(RX_EMPTY), .RX_CNT(RX_CNT),
    .CS(CS), .W_STB(W_STB), .W_DATA(W_DATA), .W_ACK(W_ACK), .R_STB(R_STB),
    .R_DATA(R_DATA)
  );

  always #5 IN_SCLK = ~IN_SCLK;

  // Passive event counters, sampled mid-cycle.
  int         n_stb = 0, n_done = 0, n_err = 0, n_cslow = 0, n_csrise = 0;
  logic       cs_q = 1'b1;
  logic [7:0] wlog [256];
  always @(negedge IN_SCLK) begin
    cs_q <= CS;
    if (W_STB) begin
      wlog[n_stb[7:0]] <= W_DATA;
      n_stb <= n_stb + 1;
    end
    if (DONE)         n_done   <= n_done + 1;
    if (ERR)          n_err    <= n_err + 1;
    if (!CS)          n_cslow  <= n_cslow + 1;
    if (CS && !cs_q)  n_csrise <= n_csrise + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge IN_SCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    TX_DATA = d;
    TX_WR   = 1'b1;
    tick();
    TX_WR   = 1'b0;
  endtask

  task automatic wait_stb(output int k);
    k = 0;
    while (!W_STB && k < 100) begin tick(); k++; end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!DONE && k < 200) begin tick(); k++; end
  endtask

  typedef struct {
    logic       stb;
    logic [7:0] dat;
    logic       rd;
    logic [4:0] cnt;
    logic       empty;
    logic [7:0] head;
  } rx_vec_t;

  rx_vec_t vecs [9];

  initial begin
    int k, e, s0, d0, r0, c0, e0;

    vecs[0] = '{1'b1, 8'h40, 1'b0, 5'd1, 1'b0, 8'h40};
    vecs[1] = '{1'b1, 8'h41, 1'b0, 5'd2, 1'b0, 8'h40};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 8'h41};
    vecs[3] = '{1'b1, 8'h42, 1'b1, 5'd1, 1'b0, 8'h42};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h00};
    vecs[6] = '{1'b1, 8'h43, 1'b1, 5'd1, 1'b0, 8'h43};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h43};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h00};

    // Reset values
    repeat (3) tick();
    RST = 1'b1;
    tick();
    check("rst_cs", CS, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_ovf", RX_OVF, 0);
    check("rst_wstb", W_STB, 0);
    check("rst_wdata", W_DATA, 0);
    check("rst_txfull", TX_FULL, 0);
    check("rst_rxempty", RX_EMPTY, 1);
    check("rst_rxcnt", RX_CNT, 0);
    check("rst_rxdata", RX_DATA, 0);

    // Basic two-byte frame, each byte acked 10 cycles after its strobe
    push_tx(8'hA5);
    push_tx(8'h3C);
    s0 = n_stb; d0 = n_done; e0 = n_err; c0 = n_cslow;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("basic_cs_low", CS, 0);
    check("basic_busy", BUSY, 1);
    wait_stb(k);
    check("basic_setup_lat", k, CS_SETUP);
    check("basic_wdata0", W_DATA, 8'hA5);
    repeat (10) tick();
    W_ACK = 1'b1; R_STB = 1'b1; R_DATA = 8'h11;
    tick();
    W_ACK = 1'b0; R_STB = 1'b0;
    check("basic_next_stb", W_STB, 1);
    check("basic_wdata1", W_DATA, 8'h3C);
    check("basic_rx_head", RX_DATA, 8'h11);
    repeat (10) tick();
    W_ACK = 1'b1; R_STB = 1'b1; R_DATA = 8'h22;
    tick();
    W_ACK = 1'b0; R_STB = 1'b0;
    wait_done(k);
    check("basic_hold_lat", k, CS_HOLD);
    check("basic_done_cs", CS, 1);
    check("basic_done_err", ERR, 0);
    check("basic_done_busy", BUSY, 1);
    tick();
    check("basic_busy_after", BUSY, 0);
    check("basic_nstb", n_stb - s0, 2);
    check("basic_ndone", n_done - d0, 1);
    check("basic_nerr", n_err - e0, 0);
    // setup + 11 cycles per byte (strobe to ack is 10, ack to next strobe is 1) + hold
    check("basic_cs_window", n_cslow - c0, CS_SETUP + 2 * 11 + CS_HOLD);
    check("basic_rxcnt", RX_CNT, 2);
    RX_RD = 1'b1;
    check("basic_rx0", RX_DATA, 8'h11);
    tick();
    check("basic_rx1", RX_DATA, 8'h22);
    tick();
    RX_RD = 1'b0;
    check("basic_rx_drained", RX_EMPTY, 1);

    // START with nothing queued
    s0 = n_stb;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("empty_done", DONE, 1);
    check("empty_cs", CS, 1);
    tick();
    check("empty_done_pulse", DONE, 0);
    check("empty_nstb", n_stb - s0, 0);

    // Timeout with three bytes queued; RX FIFO vectors run inside the open frame
    push_tx(8'hB0);
    push_tx(8'hB1);
    push_tx(8'hB2);
    s0 = n_stb; d0 = n_done; e0 = n_err;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_stb(k);
    check("to_wdata", W_DATA, 8'hB0);
    e = 0;
    for (int i = 0; i < 9; i++) begin
      R_STB = vecs[i].stb; R_DATA = vecs[i].dat; RX_RD = vecs[i].rd;
      tick();
      e++;
      check($sformatf("rxvec%0d_cnt", i), RX_CNT, vecs[i].cnt);
      check($sformatf("rxvec%0d_empty", i), RX_EMPTY, vecs[i].empty);
      check($sformatf("rxvec%0d_head", i), RX_DATA, vecs[i].head);
    end
    R_STB = 1'b0; RX_RD = 1'b0;
    while (!DONE && e < 200) begin tick(); e++; end
    check("to_done_lat", e, 1 + ACK_TIMEOUT + CS_HOLD);
    check("to_err", ERR, 1);
    check("to_cs", CS, 1);
    tick();
    check("to_nstb", n_stb - s0, 1);
    check("to_ndone", n_done - d0, 1);
    check("to_nerr", n_err - e0, 1);
    s0 = n_stb;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("to_flushed_done", DONE, 1);
    tick();
    check("to_flushed_nstb", n_stb - s0, 0);

    // FIFO bounds: 17 writes, 17 received bytes in one frame
    for (int i = 0; i < 16; i++) begin
      push_tx(8'(i));
      check($sformatf("txfull_after%0d", i + 1), TX_FULL, (i == 15) ? 1 : 0);
    end
    push_tx(8'hEE);
    check("txfull_17", TX_FULL, 1);
    s0 = n_stb; d0 = n_done;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int j = 0; j < 17; j++) begin
      R_STB = 1'b1; R_DATA = 8'h60 + 8'(j);
      tick();
    end
    R_STB = 1'b0;
    for (int i = 0; i < 16; i++) begin
      W_ACK = 1'b1;
      tick();
      W_ACK = 1'b0;
      if (i < 15) begin
        wait_stb(k);
        tick();
      end
    end
    wait_done(k);
    check("bound_err", ERR, 0);
    tick();
    check("bound_nstb", n_stb - s0, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("bound_wdata%0d", i), wlog[8'(s0 + i)], i);
    check("bound_rxcnt", RX_CNT, 16);
    check("bound_ovf", RX_OVF, 1);
    check("bound_rxhead", RX_DATA, 8'h60);

    push_tx(8'h77);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("ovf_cleared", RX_OVF, 0);
    wait_stb(k);
    tick();
    W_ACK = 1'b1;
    tick();
    W_ACK = 1'b0;
    wait_done(k);
    check("ovf_frame_done", DONE, 1);
    tick();

    // Streaming: second byte written after START extends the same CS window
    push_tx(8'h5A);
    s0 = n_stb; r0 = n_csrise;
    START = 1'b1;
    tick();
    START = 1'b0;
    push_tx(8'h6B);
    wait_stb(k);
    check("stream_wdata0", W_DATA, 8'h5A);
    tick();
    W_ACK = 1'b1;
    tick();
    W_ACK = 1'b0;
    check("stream_stb1", W_STB, 1);
    check("stream_wdata1", W_DATA, 8'h6B);
    tick();
    W_ACK = 1'b1;
    tick();
    W_ACK = 1'b0;
    wait_done(k);
    check("stream_done", DONE, 1);
    tick();
    check("stream_nstb", n_stb - s0, 2);
    check("stream_cs_windows", n_csrise - r0, 1);

    // Asynchronous reset while waiting for an acknowledge
    while (!RX_EMPTY) begin RX_RD = 1'b1; tick(); end
    RX_RD = 1'b0;
    push_tx(8'h99);
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_stb(k);
    tick();
    R_STB = 1'b1; R_DATA = 8'hC3;
    tick();
    R_STB = 1'b0;
    check("mid_rx_nonempty", RX_EMPTY, 0);
    check("mid_cs_low", CS, 0);
    d0 = n_done;
    #3;
    RST = 1'b0;
    #1;
    check("mid_rst_cs", CS, 1);
    check("mid_rst_rxempty", RX_EMPTY, 1);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_rxcnt", RX_CNT, 0);
    tick();
    tick();
    RST = 1'b1;
    repeat (5) tick();
    check("mid_no_done", n_done - d0, 0);
    check("mid_after_cs", CS, 1);
    check("mid_after_busy", BUSY, 0);
    check("mid_after_txfull", TX_FULL, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
